// File: rtl/trap_seq_pkg.sv
// trap_seq_pkg: shared phase encoding, command record and default widths for the trapezoid sequencer
package trap_seq_pkg;
  localparam int DW_DEF = 9;
  localparam int CW_DEF = 8;
  localparam int RW_DEF = 4;
  typedef enum logic [1:0] {IDLE, RISE, HOLD, FALL} phase_e;
  typedef struct packed {
    logic [DW_DEF-1:0] peak;
    logic [CW_DEF-1:0] hold;
    logic [RW_DEF-1:0] rep;
  } cmd_t;
endpackage

// File: rtl/trap_cmd_fifo.sv
// trap_cmd_fifo: synchronous command FIFO with flush; pops coinciding with a flush are dropped
module trap_cmd_fifo
  import trap_seq_pkg::*;
#(
  parameter type T = cmd_t,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  T wdata,
  output T rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign wr = push && !full && !flush;
  assign rd = pop && !empty && !flush;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign rdata = mem[rp];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      level <= level + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk) if (wr) mem[wp] <= wdata;
endmodule

// File: rtl/trap_seq_ctrl.sv
// trap_seq_ctrl: plays queued peak/hold/repeat profiles as unit-step trapezoid ramps with abort
module trap_seq_ctrl
  import trap_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int RW = RW_DEF,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic res,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic [DW-1:0] cmd_peak,
  input  logic [CW-1:0] cmd_hold,
  input  logic [RW-1:0] cmd_rep,
  input  logic abort,
  output logic [DW-1:0] d_out,
  output logic busy,
  output logic [1:0] phase,
  output logic done,
  output logic aborted,
  output logic [$clog2(DEPTH):0] fifo_level
);
  typedef struct packed {
    logic [DW-1:0] peak;
    logic [CW-1:0] hold;
    logic [RW-1:0] rep;
  } lcmd_t;
  localparam logic [DW-1:0] ONE = DW'(1);
  lcmd_t q;
  phase_e st, st_n;
  logic [DW-1:0] d_n, peak, peak_n;
  logic [CW-1:0] hold, hold_n, hcnt, hcnt_n;
  logic [RW-1:0] rep_left, rep_n;
  logic abt, abt_n, done_n, aborted_n, pop, full, empty;
  assign cmd_ready = !full && !abort;
  assign phase = st;
  assign busy = st != IDLE || !empty;
  trap_cmd_fifo #(.T(lcmd_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(res),
    .push(cmd_valid && cmd_ready),
    .pop(pop),
    .flush(abort),
    .wdata({cmd_peak, cmd_hold, cmd_rep}),
    .rdata(q),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  // abt remembers a past abort so the ramp-down ends with aborted rather than done
  always_comb begin
    st_n = st;
    d_n = d_out;
    peak_n = peak;
    hold_n = hold;
    hcnt_n = hcnt;
    rep_n = abort ? '0 : rep_left;
    abt_n = abt;
    done_n = 1'b0;
    aborted_n = 1'b0;
    pop = 1'b0;
    if (st == FALL || (abort && st != IDLE)) begin
      d_n = d_out > ONE ? d_out - ONE : '0;
      abt_n = abt || abort;
      st_n = FALL;
      if (d_out <= ONE) begin
        if (rep_left != '0 && !abort) begin
          rep_n = rep_left - 1'b1;
          st_n = RISE;
        end else begin
          st_n = IDLE;
          abt_n = 1'b0;
          done_n = !(abt || abort);
          aborted_n = abt || abort;
        end
      end
    end else if (st == RISE) begin
      d_n = d_out + ONE;
      hcnt_n = '0;
      if (d_out == peak - ONE) st_n = hold == '0 ? FALL : HOLD;
    end else if (st == HOLD) begin
      hcnt_n = hcnt + 1'b1;
      if (hcnt == hold - 1'b1) st_n = FALL;
    end else if (!empty && !abort) begin
      pop = 1'b1;
      peak_n = q.peak;
      hold_n = q.hold;
      rep_n = q.rep;
      st_n = q.peak == '0 ? IDLE : RISE;
      done_n = q.peak == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (res) begin
      st <= IDLE;
      d_out <= '0;
      peak <= '0;
      hold <= '0;
      hcnt <= '0;
      rep_left <= '0;
      abt <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      st <= st_n;
      d_out <= d_n;
      peak <= peak_n;
      hold <= hold_n;
      hcnt <= hcnt_n;
      rep_left <= rep_n;
      abt <= abt_n;
      done <= done_n;
      aborted <= aborted_n;
    end
  end
endmodule

// File: tb/tb_trap_seq_ctrl.sv
// tb_trap_seq_ctrl: directed vectors with hand-computed expectations for trap_seq_ctrl
module tb_trap_seq_ctrl;
  logic clk = 1'b0;
  logic res, cmd_valid, cmd_ready, abort, busy, done, aborted;
  logic [8:0] cmd_peak, d_out;
  logic [7:0] cmd_hold;
  logic [3:0] cmd_rep;
  logic [1:0] phase;
  logic [2:0] fifo_level;
  int nvec = 0;
  int nerr = 0;
  int acc, ndone;
  int t1d[11] = '{0, 0, 1, 2, 3, 3, 3, 2, 1, 0, 0};
  int t1p[11] = '{0, 1, 1, 1, 2, 2, 3, 3, 3, 0, 0};
  int t2d[15] = '{0, 0, 1, 2, 1, 0, 1, 2, 1, 0, 1, 2, 1, 0, 0};
  int t2p[15] = '{0, 1, 1, 3, 3, 1, 1, 3, 3, 1, 1, 3, 3, 0, 0};
  int pat[10] = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0};
  trap_seq_ctrl dut (
    .clk(clk), .res(res), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_peak(cmd_peak), .cmd_hold(cmd_hold), .cmd_rep(cmd_rep), .abort(abort),
    .d_out(d_out), .busy(busy), .phase(phase), .done(done), .aborted(aborted),
    .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_cmd(input int p, input int h, input int r);
    cmd_peak = 9'(p);
    cmd_hold = 8'(h);
    cmd_rep = 4'(r);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  initial begin
    res = 1'b1;
    cmd_valid = 1'b0;
    abort = 1'b0;
    set_cmd(0, 0, 0);
    tick();
    tick();
    chk("rst_d", d_out, 0);
    chk("rst_phase", phase, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    res = 1'b0;
    tick();
    chk("idle_d", d_out, 0);
    // single trapezoid P=3 H=2
    set_cmd(3, 2, 0);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("t1_level", fifo_level, 1);
    for (int i = 0; i < 11; i++) begin
      chk("t1_d", d_out, t1d[i]);
      chk("t1_phase", phase, t1p[i]);
      chk("t1_done", done, i == 9);
      tick();
    end
    // three triangles P=2 R=2
    set_cmd(2, 0, 2);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("t2_d", d_out, t2d[i]);
      chk("t2_phase", phase, t2p[i]);
      chk("t2_done", done, i == 13);
      tick();
    end
    // six back-to-back commands P=4 H=1 against a 4-deep queue
    set_cmd(4, 1, 0);
    cmd_valid = 1'b1;
    acc = 0;
    ndone = 0;
    for (int i = 0; i <= 60; i++) begin
      if (cmd_valid && cmd_ready) acc++;
      tick();
      if (acc == 6) cmd_valid = 1'b0;
      ndone += int'(done);
      if (i == 0) chk("t3_level0", fifo_level, 1);
      if (i > 0) chk("t3_d", d_out, pat[(i-1)%10]);
      chk("t3_done", done, i % 10 == 0 && i > 0);
      if (i == 4 || i == 10) begin
        chk("t3_level_full", fifo_level, 4);
        chk("t3_ready_full", cmd_ready, 0);
      end
    end
    chk("t3_accepted", acc, 6);
    chk("t3_ndone", ndone, 6);
    chk("t3_busy", busy, 0);
    chk("t3_level_end", fifo_level, 0);
    // abort on third HOLD cycle with two commands queued
    for (int i = 0; i <= 24; i++) begin
      if (i == 0) begin set_cmd(10, 20, 0); cmd_valid = 1'b1; end
      if (i == 1) set_cmd(5, 0, 0);
      if (i == 2) set_cmd(7, 0, 0);
      if (i == 3) cmd_valid = 1'b0;
      if (i == 14) begin
        abort = 1'b1;
        #1;
        chk("t4_ready_abort", cmd_ready, 0);
      end
      if (i == 15) abort = 1'b0;
      tick();
      chk("t4_d", d_out, i == 0 ? 0 : i <= 10 ? i - 1 : i <= 13 ? 10 : i <= 23 ? 23 - i : 0);
      chk("t4_phase", phase, (i == 0 || i >= 23) ? 0 : i <= 10 ? 1 : i <= 13 ? 2 : 3);
      chk("t4_aborted", aborted, i == 23);
      chk("t4_done", done, 0);
      chk("t4_level", fifo_level, i <= 1 ? 1 : i <= 13 ? 2 : 0);
    end
    repeat (5) tick();
    chk("t4_idle_phase", phase, 0);
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_d", d_out, 0);
    // zero-peak command
    set_cmd(0, 5, 3);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("t5_done0", done, 0);
    chk("t5_level0", fifo_level, 1);
    tick();
    chk("t5_done1", done, 1);
    chk("t5_d1", d_out, 0);
    chk("t5_phase1", phase, 0);
    chk("t5_busy1", busy, 0);
    tick();
    chk("t5_done2", done, 0);
    // full-scale peak 511 without hold
    set_cmd(511, 0, 0);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i <= 1024; i++) begin
      chk("t6_d", d_out, i == 0 ? 0 : i <= 512 ? i - 1 : i <= 1023 ? 1023 - i : 0);
      chk("t6_done", done, i == 1023);
      if (i == 511) chk("t6_phase_rise", phase, 1);
      if (i == 512) chk("t6_phase_fall", phase, 3);
      if (i == 1023) chk("t6_phase_idle", phase, 0);
      tick();
    end
    // reset mid-RISE with queued commands
    set_cmd(20, 0, 0);
    for (int i = 0; i <= 6; i++) begin
      cmd_valid = i <= 2;
      tick();
    end
    cmd_valid = 1'b0;
    chk("t7_d_pre", d_out, 5);
    chk("t7_phase_pre", phase, 1);
    chk("t7_level_pre", fifo_level, 2);
    res = 1'b1;
    tick();
    chk("t7_d_rst", d_out, 0);
    chk("t7_phase_rst", phase, 0);
    chk("t7_level_rst", fifo_level, 0);
    chk("t7_busy_rst", busy, 0);
    chk("t7_ready_rst", cmd_ready, 1);
    res = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("t7_no_replay_d", d_out, 0);
      chk("t7_no_replay_busy", busy, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
